demux1_to_4_buf: RTL and testbench

DEMUX1_TO_4_BUF -- requirements
Module: demux1_to_4_buf

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_slot.sv | 40 ++++
 rtl/demux1_to_4_buf.sv | 90 +++++++++
 tb/tb_demux1_to_4_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and the channel index type for the 1:4 demux.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef logic [CH_W-1:0] ch_t;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer for a single demux channel.
// A load on the same edge as a drain replaces the word and keeps valid high.
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next state: a load always wins; otherwise a drain empties the slot and data is retained.
   always_comb begin
      valid_d = load | (valid_q & ~drain);
      data_d  = load ? load_data : data_q;
   end

   // Slot register; reset discards any held word and zeroes the data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule : demux_slot

// File: rtl/demux1_to_4_buf.sv
// demux1_to_4_buf: routes one valid/ready input stream to one of four
// buffered output channels. The destination is sel by default; defining
// DEMUX_RR_EN ignores sel and distributes words round-robin instead.
module demux1_to_4_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [1:0]        sel,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [WIDTH-1:0]  out_data0,
   output logic [WIDTH-1:0]  out_data1,
   output logic [WIDTH-1:0]  out_data2,
   output logic [WIDTH-1:0]  out_data3
);

   ch_t              ch;
   logic             accept;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] slot_valid;
   logic [WIDTH-1:0] slot_data [NUM_CH];

`ifdef DEMUX_RR_EN
   ch_t  ptr_q;
   ch_t  ptr_d;
   logic unused_sel;

   assign unused_sel = ^sel;

   // Pointer advances once per accepted word and wraps naturally at 3 -> 0.
   always_comb begin
      ptr_d = accept ? ptr_q + 1'b1 : ptr_q;
   end

   // Round-robin pointer register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ch = ptr_q;
`else
   assign ch = ch_t'(sel);
`endif

   // Ready follows the destination slot only, so it never depends on in_valid;
   // a slot being drained this cycle can take a new word without a bubble.
   always_comb begin
      in_ready = ~slot_valid[ch] | out_ready[ch];
      accept   = in_valid & in_ready;
   end

   // One-hot load decode toward the selected slot.
   always_comb begin
      load = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         load[k] = accept && (ch == ch_t'(k));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clock     (clock),
         .reset_n   (reset_n),
         .load      (load[g]),
         .drain     (out_ready[g]),
         .load_data (in_data),
         .valid     (slot_valid[g]),
         .data      (slot_data[g])
      );
   end

   assign out_valid = slot_valid;
   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];
   assign out_data3 = slot_data[3];

endmodule : demux1_to_4_buf

// File: tb/tb_demux1_to_4_buf.sv
// tb_demux1_to_4_buf: directed and random checks of demux1_to_4_buf against a
// per-channel scoreboard. Build with DEMUX_RR_EN to exercise round-robin mode.
module tb_demux1_to_4_buf;

   localparam int WIDTH = 8;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] sel;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data0;
   logic [7:0] out_data1;
   logic [7:0] out_data2;
   logic [7:0] out_data3;
   logic [7:0] obs_data [4];

   int         num_asserts  = 0;
   int         num_failures = 0;

   logic [7:0] sb_q [4][$];
   logic [7:0] last_data [4];
   logic [1:0] rr_ptr;

   demux1_to_4_buf #(
      .WIDTH (WIDTH)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3)
   );

   assign obs_data[0] = out_data0;
   assign obs_data[1] = out_data1;
   assign obs_data[2] = out_data2;
   assign obs_data[3] = out_data3;

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_asserts++;
      assert (observed === expected) else begin
         num_failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [1:0] modelCh(input logic [1:0] s);
`ifdef DEMUX_RR_EN
      return rr_ptr;
`else
      return s;
`endif
   endfunction

   function automatic logic modelReady(input logic [1:0] s, input logic [3:0] ordy);
      logic [1:0] c;
      c = modelCh(s);
      return (sb_q[c].size() == 0) || ordy[c];
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 4; k++) begin
         sb_q[k].delete();
         last_data[k] = 8'h00;
      end
      rr_ptr = 2'd0;
   endtask

   // Compare every output against the scoreboard; held words must match the queue head.
   task automatic checkOutput(input logic [1:0] s, input logic [3:0] ordy);
      logic exp_v;
      for (int k = 0; k < 4; k++) begin
         exp_v = (sb_q[k].size() != 0);
         checkValue($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]}, {31'd0, exp_v});
         checkValue($sformatf("out_data%0d", k), {24'd0, obs_data[k]},
                    {24'd0, (exp_v ? sb_q[k][0] : last_data[k])});
      end
      checkValue("in_ready", {31'd0, in_ready}, {31'd0, modelReady(s, ordy)});
   endtask

   // One cycle: drive at the falling edge, check, then update the model at the rising edge.
   task automatic applyStimulus(input logic iv, input logic [1:0] s, input logic [7:0] d, input logic [3:0] ordy);
      logic       acc;
      logic [1:0] c;
      @(negedge clock);
      in_valid  = iv;
      sel       = s;
      in_data   = d;
      out_ready = ordy;
      #1;
      checkOutput(s, ordy);
      acc = iv && modelReady(s, ordy);
      c   = modelCh(s);
      @(posedge clock);
      for (int k = 0; k < 4; k++) begin
         if (sb_q[k].size() != 0 && ordy[k]) begin
            void'(sb_q[k].pop_front());
         end
      end
      if (acc) begin
         sb_q[c].push_back(d);
         last_data[c] = d;
         rr_ptr       = rr_ptr + 2'd1;
      end
   endtask

   initial begin
      int total;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      sel       = 2'd0;
      in_data   = 8'h00;
      out_ready = 4'h0;
      modelReset();

      // Reset state, including ready high while held in reset.
      #12;
      checkValue("rst_out_valid", {28'd0, out_valid}, 32'h0);
      checkValue("rst_in_ready", {31'd0, in_ready}, 32'h1);
      checkValue("rst_data2", {24'd0, out_data2}, 32'h0);
      @(posedge clock);
      #2;
      reset_n = 1'b1;

`ifndef DEMUX_RR_EN
      // Single word to channel 2, first edge after release.
      applyStimulus(1'b1, 2'd2, 8'hA5, 4'h0);
      #2;
      checkValue("req027_valid", {28'd0, out_valid}, 32'h4);
      checkValue("req027_data2", {24'd0, out_data2}, 32'hA5);
      checkValue("req027_data0", {24'd0, out_data0}, 32'h0);

      // Back-pressure on channel 1.
      applyStimulus(1'b1, 2'd1, 8'h11, 4'h0);
      applyStimulus(1'b1, 2'd1, 8'h22, 4'h0);
      #2;
      checkValue("req028_hold", {24'd0, out_data1}, 32'h11);
      applyStimulus(1'b1, 2'd1, 8'h22, 4'b0010);
      #2;
      checkValue("req028_data1", {24'd0, out_data1}, 32'h22);
      checkValue("req028_valid1", {31'd0, out_valid[1]}, 32'h1);

      // Simultaneous drain and reload on channel 3.
      applyStimulus(1'b1, 2'd3, 8'h30, 4'h0);
      applyStimulus(1'b1, 2'd3, 8'h33, 4'b1000);
      #2;
      checkValue("req029_valid3", {31'd0, out_valid[3]}, 32'h1);
      checkValue("req029_data3", {24'd0, out_data3}, 32'h33);
`else
      // Round-robin distribution with sel stuck at 0.
      for (int i = 0; i < 5; i++) begin
         logic [3:0] exp_ch [5];
         exp_ch = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
         applyStimulus(1'b1, 2'd0, 8'(i + 1), 4'hF);
         #2;
         checkValue($sformatf("req031_valid_w%0d", i + 1), {28'd0, out_valid}, 32'(1 << exp_ch[i]));
         checkValue($sformatf("req031_data_w%0d", i + 1), {24'd0, obs_data[exp_ch[i][1:0]]}, 32'(i + 1));
      end
`endif

      // Empty every slot, then fill all four and reset in the middle of a cycle.
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 2'(k), 8'(8'h40 + k), 4'h0);
      end
      #2;
      checkValue("req030_full", {28'd0, out_valid}, 32'hF);
      reset_n = 1'b0;
      #1;
      checkValue("req030_valid", {28'd0, out_valid}, 32'h0);
      checkValue("req030_data1", {24'd0, out_data1}, 32'h0);
      checkValue("req030_ready", {31'd0, in_ready}, 32'h1);
      modelReset();
      @(posedge clock);
      #2;
      reset_n = 1'b1;

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       8'($urandom), 4'($urandom));
      end
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
      total = 0;
      for (int k = 0; k < 4; k++) begin
         total += sb_q[k].size();
      end
      checkValue("sb_empty", 32'(total), 32'h0);
      checkValue("final_valid", {28'd0, out_valid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_failures);
      $finish;
   end

endmodule : tb_demux1_to_4_buf
